// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode/stat/register constants and pipeline-control state encoding
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    // "No register" ID
    localparam logic [3:0] R_NONE = 4'hF;

    // Run-state encoding
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Instructions that write a register from memory in the M stage
    function automatic logic is_mem_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - cycle, retirement, load-use and mispredict counters
module pipe_perf_cnt
    import y86_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halted,
    input  logic             ret_en,
    input  logic             lu_en,
    input  logic             mp_en,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // All counters freeze once the machine has halted; they wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
            lu_cnt  <= '0;
            mp_cnt  <= '0;
        end else if (!halted) begin
            cyc_cnt <= cyc_cnt + ONE;
            if (ret_en) ret_cnt <= ret_cnt + ONE;
            if (lu_en)  lu_cnt  <= lu_cnt + ONE;
            if (mp_en)  mp_cnt  <= mp_cnt + ONE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline stall/bubble control, run-state FSM and debug counters
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [3:0]       cpu_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       loaduse;
    logic       retp;
    logic       mispred;
    logic       mexc;
    logic       wexc;
    logic       ret_en;

    // Hazard detection terms
    always_comb begin
        loaduse = is_mem_load(E_icode) && (E_dstM != R_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred = (E_icode == I_JXX) && !e_Cnd;
        mexc    = (m_stat != S_AOK);
        wexc    = (W_stat != S_AOK);
    end

    // Stall/bubble controls; reset forces a flush, HALTED freezes everything
    always_comb begin
        F_stall  = loaduse | retp;
        D_stall  = loaduse;
        D_bubble = mispred | (retp & !loaduse);
        E_bubble = mispred | loaduse;
        M_bubble = mexc | wexc;
        W_stall  = wexc;
        set_cc   = (E_icode == I_OPQ) && !mexc && !wexc && (state == ST_RUN);
        if (state == ST_HALTED) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            set_cc   = 1'b0;
        end
        if (rst) begin
            F_stall  = 1'b0;
            D_stall  = 1'b0;
            W_stall  = 1'b0;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            set_cc   = 1'b0;
        end
    end

    // Next run state: a W-stage exception wins over an M-stage one
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (wexc)      state_nxt = ST_HALTED;
                else if (mexc) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wexc) state_nxt = ST_HALTED;
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

    // Run state and architectural status; status is captured on HALTED entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            cpu_stat <= S_AOK;
        end else begin
            state <= state_nxt;
            if ((state != ST_HALTED) && (state_nxt == ST_HALTED)) begin
                cpu_stat <= W_stat;
            end
        end
    end

    assign halted = (state == ST_HALTED);
    assign ret_en = (W_stat == S_AOK) && (W_icode != I_NOP) && !W_stall;

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk     (clk),
        .rst     (rst),
        .halted  (halted),
        .ret_en  (ret_en),
        .lu_en   (loaduse),
        .mp_en   (mispred),
        .cyc_cnt (cyc_cnt),
        .ret_cnt (ret_cnt),
        .lu_cnt  (lu_cnt),
        .mp_cnt  (mp_cnt)
    );

endmodule
